compare_seq_ctrl: RTL and testbench

//   Sequencing controller for a bit-serial magnitude compare of two WIDTH-bit operands.

---
 rtl/compare_seq_ctrl.sv | 93 +++++++++
 tb/tb_compare_seq_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/compare_seq_ctrl.sv
// compare_seq_ctrl: bit-serial MSB-first magnitude compare sequencer with one-hot E/L/G result
module compare_seq_ctrl #(
    parameter int WIDTH = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_signed_mode,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_e,
    output logic             o_l,
    output logic             o_g
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] MSB = IW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_CMP, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic            r_sm;
    logic [IW-1:0]   r_idx;
    logic            r_e;
    logic            r_l;
    logic            r_g;
    logic            w_accept;
    logic            w_diff;
    logic            w_last;
    logic            w_gt;

    assign w_accept = i_start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_diff   = r_a[r_idx] != r_b[r_idx];
    assign w_last   = r_idx == '0;
    // at the sign bit of a signed compare a 1 means the smaller operand
    assign w_gt     = (r_sm && r_idx == MSB) ? ~r_a[r_idx] : r_a[r_idx];
    assign o_busy   = r_state == S_CMP;
    assign o_done   = r_state == S_DONE;
    assign o_e      = r_e;
    assign o_l      = r_l;
    assign o_g      = r_g;

    // state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // next state: finish on first differing bit or after the LSB
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:  w_next = i_start ? S_CMP : S_IDLE;
            S_CMP:   w_next = (w_diff || w_last) ? S_DONE : S_CMP;
            S_DONE:  w_next = i_start ? S_CMP : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // operand latch, bit walk and result flags
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sm  <= 1'b0;
            r_idx <= '0;
            r_e   <= 1'b0;
            r_l   <= 1'b0;
            r_g   <= 1'b0;
        end else if (w_accept) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_sm  <= i_signed_mode;
            r_idx <= MSB;
            r_e   <= 1'b0;
            r_l   <= 1'b0;
            r_g   <= 1'b0;
        end else if (r_state == S_CMP) begin
            if (w_diff) begin
                r_g <= w_gt;
                r_l <= ~w_gt;
            end else if (w_last) begin
                r_e <= 1'b1;
            end else begin
                r_idx <= r_idx - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_compare_seq_ctrl.sv
// tb_compare_seq_ctrl: directed scoreboard bench for compare_seq_ctrl
module tb_compare_seq_ctrl;
    localparam int W = 3;

    typedef struct {
        logic [2:0] elg;
        int         lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sm = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, e, l, g;
    int           checks = 0;
    int           failures = 0;
    exp_t         q[$];

    compare_seq_ctrl #(.WIDTH(W)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_signed_mode(sm),
        .i_a(a), .i_b(b), .o_busy(busy), .o_done(done), .o_e(e), .o_l(l), .o_g(g)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msm);
        exp_t r;
        logic lt;
        lt = msm ? ($signed(ma) < $signed(mb)) : (ma < mb);
        r.elg = (ma == mb) ? 3'b100 : (lt ? 3'b010 : 3'b001);
        r.lat = W;
        for (int i = 0; i < W; i++) if (ma[i] != mb[i]) r.lat = W - i;
        return r;
    endfunction

    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsm);
        a = ta;
        b = tb;
        sm = tsm;
        start = 1'b1;
        q.push_back(model(ta, tb, tsm));
    endtask

    task automatic collect(input int n0);
        int   n;
        exp_t x;
        n = n0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("latency", n, x.lat);
            chk("elg", {29'd0, e, l, g}, {29'd0, x.elg});
        end else begin
            chk("queue_nonempty", 32'd0, 32'd1);
        end
    endtask

    task automatic run(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsm);
        logic [2:0] res;
        @(negedge clk);
        launch(ta, tb, tsm);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("elg_clear_busy", {29'd0, e, l, g}, 32'd0);
        collect(0);
        res = {e, l, g};
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("elg_hold_idle", {29'd0, e, l, g}, {29'd0, res});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_elg", {29'd0, e, l, g}, 32'd0);
        rst = 1'b0;

        run(3'b101, 3'b011, 1'b0);
        run(3'b110, 3'b110, 1'b0);
        run(3'b101, 3'b011, 1'b1);
        run(3'b110, 3'b101, 1'b1);
        run(3'b100, 3'b011, 1'b1);
        run(3'b010, 3'b011, 1'b0);
        for (int i = 0; i < 6; i++)
            run(W'($urandom_range(0, 7)), W'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));

        @(negedge clk);
        launch(3'b000, 3'b000, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_elg", {29'd0, e, l, g}, 32'd0);
        q.delete();
        @(negedge clk);
        chk("rst_hold_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", {31'd0, busy}, 32'd0);
        run(3'b011, 3'b100, 1'b0);

        @(negedge clk);
        launch(3'b000, 3'b000, 1'b0);
        @(negedge clk);
        a = 3'b111;
        b = 3'b000;
        sm = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("cmp_ignores_start", {31'd0, busy}, 32'd1);
        collect(1);
        launch(3'b111, 3'b000, 1'b1);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        chk("b2b_done_low", {31'd0, done}, 32'd0);
        chk("b2b_elg_clear", {29'd0, e, l, g}, 32'd0);
        collect(0);
        @(negedge clk);
        chk("b2b_done_one_cycle", {31'd0, done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
